// File: rtl/ps2_rx_frame_pkg.sv
// Shared types and constants for the PS/2 receive front end.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int FRAME_BITS      = 11;
    localparam int DATA_BITS       = 8;
    localparam int DEF_FILTER_LEN  = 8;
    localparam int DEF_TIMEOUT_CYC = 50000;

    // Odd parity holds when data plus parity bit carries an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// Pin-side and byte-side signals of the PS/2 receiver, grouped for port passing.
interface ps2_rx_frame_if;
    logic       ps2c;
    logic       ps2d;
    logic       rx_en;
    logic [7:0] data;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport master (
        output ps2c, ps2d, rx_en,
        input  data, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  ps2c, ps2d, rx_en,
        output data, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/ps2_rx_frame_filter.sv
// Synchronises and de-glitches the device-driven PS/2 clock; emits a pulse on each
// filtered falling edge, 2 + FILTER_LEN cycles after the pin edge.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_in,
    input  logic raw,
    output logic filt,
    output logic fall_tick
);
    localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

    logic       r_s1;
    logic       r_s2;
    logic       r_filt;
    logic       r_prev;
    logic [7:0] r_cnt;

    // r_cnt counts consecutive synced samples that disagree with r_filt;
    // any agreeing sample restarts the run, so short glitches never get through.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_filt <= 1'b1;
            r_prev <= 1'b1;
            r_cnt  <= 8'd0;
        end else begin
            r_s1   <= raw;
            r_s2   <= r_s1;
            r_prev <= r_filt;
            if (r_s2 == r_filt) begin
                r_cnt <= 8'd0;
            end else if (r_cnt == CNT_LAST) begin
                r_filt <= r_s2;
                r_cnt  <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign filt      = r_filt;
    assign fall_tick = r_prev & ~r_filt;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 keyboard receiver: deserialises start/8 data/odd parity/stop frames and
// reports each byte or error as a single-cycle strobe.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic           clk,
    input  logic           reset_in,
    ps2_rx_frame_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    // Counter reads 0 the cycle after a fall_tick and the strobe is registered,
    // so aborting at this value lands frame_err TIMEOUT_CYC-1 cycles after the tick.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 3);

    logic       r_d1;
    logic       r_d2;
    logic       w_ps2c_filt;
    logic       w_fall;

    ps2_state_t            r_state,  w_state_nx;
    logic [3:0]            r_bitcnt, w_bitcnt_nx;
    logic [DATA_BITS-1:0]  r_shreg,  w_shreg_nx;
    logic                  r_par,    w_par_nx;
    logic [DATA_BITS-1:0]  r_data,   w_data_nx;
    logic                  r_dv,     w_dv_nx;
    logic                  r_pe,     w_pe_nx;
    logic                  r_fe,     w_fe_nx;
    logic [TW-1:0]         r_to,     w_to_nx;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk       (clk),
        .reset_in  (reset_in),
        .raw       (bus.ps2c),
        .filt      (w_ps2c_filt),
        .fall_tick (w_fall)
    );

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            r_d1     <= 1'b1;
            r_d2     <= 1'b1;
            r_state  <= IDLE;
            r_bitcnt <= 4'd0;
            r_shreg  <= '0;
            r_par    <= 1'b0;
            r_data   <= '0;
            r_dv     <= 1'b0;
            r_pe     <= 1'b0;
            r_fe     <= 1'b0;
            r_to     <= '0;
        end else begin
            r_d1     <= bus.ps2d;
            r_d2     <= r_d1;
            r_state  <= w_state_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_shreg  <= w_shreg_nx;
            r_par    <= w_par_nx;
            r_data   <= w_data_nx;
            r_dv     <= w_dv_nx;
            r_pe     <= w_pe_nx;
            r_fe     <= w_fe_nx;
            r_to     <= w_to_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_bitcnt_nx = r_bitcnt;
        w_shreg_nx  = r_shreg;
        w_par_nx    = r_par;
        w_data_nx   = r_data;
        w_dv_nx     = 1'b0;
        w_pe_nx     = 1'b0;
        w_fe_nx     = 1'b0;
        w_to_nx     = (r_state == IDLE || w_fall) ? '0 : r_to + TW'(1);

        unique case (r_state)
            IDLE: begin
                if (w_fall && !w_ps2c_filt && !r_d2 && bus.rx_en) begin
                    w_state_nx  = DATA;
                    w_bitcnt_nx = 4'd0;
                end
            end
            DATA: begin
                if (w_fall) begin
                    w_shreg_nx  = {r_d2, r_shreg[DATA_BITS-1:1]};
                    w_bitcnt_nx = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'(DATA_BITS - 1))
                        w_state_nx = PARITY;
                end
            end
            PARITY: begin
                if (w_fall) begin
                    w_par_nx   = r_d2;
                    w_state_nx = STOP;
                end
            end
            STOP: begin
                if (w_fall) begin
                    w_state_nx = IDLE;
                    if (!r_d2) begin
                        w_fe_nx = 1'b1;
                    end else if (!odd_parity_ok(r_shreg, r_par)) begin
                        w_pe_nx = 1'b1;
                    end else begin
                        w_data_nx = r_shreg;
                        w_dv_nx   = 1'b1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase

        // A fall_tick on the terminal count keeps the frame alive.
        if (r_state != IDLE && !w_fall && r_to == TO_LAST) begin
            w_state_nx = IDLE;
            w_fe_nx    = 1'b1;
            w_to_nx    = '0;
        end
    end

    assign bus.data       = r_data;
    assign bus.data_valid = r_dv;
    assign bus.parity_err = r_pe;
    assign bus.frame_err  = r_fe;
    assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: table of whole frames plus hand-built glitch,
// timeout and reset sequences; host clock half-period shortened to keep runtime small.
module tb_ps2_rx_frame;
    import ps2_pkg::*;

    localparam int FL   = 8;
    localparam int TO   = 5000;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic reset_in = 1'b1;
    always #10 clk = ~clk;

    ps2_rx_frame_if bus();

    ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_v = 0, n_p = 0, n_f = 0, strobe_cyc = 0;
    always @(negedge clk) begin
        if (bus.data_valid) n_v <= n_v + 1;
        if (bus.parity_err) n_p <= n_p + 1;
        if (bus.frame_err)  n_f <= n_f + 1;
        if (bus.data_valid || bus.parity_err || bus.frame_err) strobe_cyc <= cyc;
    end

    int checks = 0;
    int fails  = 0;
    int last_fall = 0;

    typedef struct {
        logic [7:0] d;
        logic       par_ok;
        logic       stop;
        logic       rx_s;
        logic       rx_m;
        logic [7:0] e_data;
        int         e_v;
        int         e_p;
        int         e_f;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        bus.ps2d = b;
        step(HALF / 2);
        bus.ps2c = 1'b0;
        last_fall = cyc;
        step(HALF);
        bus.ps2c = 1'b1;
        step(HALF / 4);
        if (glitch) begin
            bus.ps2c = 1'b0;
            step(3);
            bus.ps2c = 1'b1;
        end
        step(HALF / 4);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic rxs, input logic rxm, input int gi);
        bus.rx_en = rxs;
        send_bit(1'b0, gi == 0);
        bus.rx_en = rxm;
        for (int i = 0; i < DATA_BITS; i++) send_bit(d[i], gi == i + 1);
        send_bit(par, gi == 9);
        send_bit(stop, gi == 10);
        step(20);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] e_data,
                               input int e_v, input int e_p, input int e_f,
                               input int v0, input int p0, input int f0);
        chk({tag, " data"}, 32'(bus.data), 32'(e_data));
        chk({tag, " data_valid count"}, n_v - v0, e_v);
        chk({tag, " parity_err count"}, n_p - p0, e_p);
        chk({tag, " frame_err count"},  n_f - f0, e_f);
        chk({tag, " busy"}, 32'(bus.busy), 32'd0);
        if (e_v + e_p + e_f > 0)
            chk({tag, " strobe latency"}, strobe_cyc - last_fall, FL + 3);
    endtask

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, p0, f0, hit_cyc;
        bit hit;
        logic par;

        vt[0] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b1, 8'h1C, 1, 0, 0};
        vt[1] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h1C, 0, 1, 0};
        vt[2] = '{8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h1C, 0, 0, 1};
        vt[3] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hF0, 1, 0, 0};
        vt[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1, 0, 0};
        vt[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 0, 1, 0};
        vt[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1, 0, 0};
        vt[7] = '{8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 0, 0, 0};
        vt[8] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1, 0, 0};

        bus.ps2c  = 1'b1;
        bus.ps2d  = 1'b1;
        bus.rx_en = 1'b1;
        step(5);
        chk("reset data",       32'(bus.data),       32'h00);
        chk("reset data_valid", 32'(bus.data_valid), 32'd0);
        chk("reset parity_err", 32'(bus.parity_err), 32'd0);
        chk("reset frame_err",  32'(bus.frame_err),  32'd0);
        chk("reset busy",       32'(bus.busy),       32'd0);
        reset_in = 1'b0;
        step(10);

        for (int k = 0; k < 9; k++) begin
            v0 = n_v; p0 = n_p; f0 = n_f;
            par = vt[k].par_ok ? ~^vt[k].d : ^vt[k].d;
            send_frame(vt[k].d, par, vt[k].stop, vt[k].rx_s, vt[k].rx_m, -1);
            frame_check($sformatf("vec%0d", k), vt[k].e_data,
                        vt[k].e_v, vt[k].e_p, vt[k].e_f, v0, p0, f0);
        end

        // 3-cycle low glitch while idle, with data low so a real edge would start a frame
        bus.rx_en = 1'b1;
        bus.ps2d  = 1'b0;
        v0 = n_v; p0 = n_p; f0 = n_f;
        step(20);
        bus.ps2c = 1'b0;
        step(3);
        bus.ps2c = 1'b1;
        step(30);
        chk("idle glitch busy", 32'(bus.busy), 32'd0);
        chk("idle glitch strobes", (n_v - v0) + (n_p - p0) + (n_f - f0), 0);
        bus.ps2d = 1'b1;
        step(20);

        // same glitch in the high phase after data bit 4
        v0 = n_v; p0 = n_p; f0 = n_f;
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 4);
        frame_check("glitch 5A", 8'h5A, 1, 0, 0, v0, p0, f0);

        // four data bits then silence
        v0 = n_v; p0 = n_p; f0 = n_f;
        bus.rx_en = 1'b1;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("timeout busy mid-frame", 32'(bus.busy), 32'd1);
        hit = 1'b0;
        hit_cyc = 0;
        for (int k = 0; k < TO + 200; k++) begin
            @(negedge clk);
            if (bus.frame_err) begin
                hit = 1'b1;
                hit_cyc = cyc;
                break;
            end
        end
        chk("timeout fired", 32'(hit), 32'd1);
        chk("timeout latency", hit_cyc - last_fall, FL + 2 + TO - 1);
        step(5);
        chk("timeout data_valid count", n_v - v0, 0);
        chk("timeout parity_err count", n_p - p0, 0);
        chk("timeout frame_err count",  n_f - f0, 1);
        chk("timeout busy", 32'(bus.busy), 32'd0);
        chk("timeout data held", 32'(bus.data), 32'h5A);
        step(20);
        v0 = n_v; p0 = n_p; f0 = n_f;
        send_frame(8'h29, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        frame_check("after timeout 29", 8'h29, 1, 0, 0, v0, p0, f0);

        // reset pulse in the middle of a frame
        v0 = n_v; p0 = n_p; f0 = n_f;
        bus.rx_en = 1'b1;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        reset_in = 1'b1;
        #2;
        chk("mid reset busy", 32'(bus.busy), 32'd0);
        chk("mid reset data", 32'(bus.data), 32'h00);
        step(2);
        reset_in = 1'b0;
        step(HALF * 4);
        chk("post reset strobes", (n_v - v0) + (n_p - p0) + (n_f - f0), 0);
        chk("post reset busy", 32'(bus.busy), 32'd0);
        bus.ps2d = 1'b1;
        step(20);
        v0 = n_v; p0 = n_p; f0 = n_f;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        frame_check("after reset 1C", 8'h1C, 1, 0, 0, v0, p0, f0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
